// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Valid/ready on both sides; overflow flags values beyond DIGITS digits.
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    bin;
    logic [BW-1:0]   bcd;
    logic [CW-1:0]   count;
    logic            ovf;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   bcd_sh;
    logic            carry;
    logic            load;
    logic            last;

    assign last = (count == CW'(W - 1));
    assign load = in_valid & in_ready;

    // Digits are corrected independently; no carry crosses a digit boundary.
    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        carry  = adj[BW-1];
        bcd_sh = {adj[BW-2:0], bin[W-1]};
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst;
                if (in_valid) begin
                    state_n = CONV;
                end
            end
            CONV: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                in_ready  = rst & out_ready;
                out_valid = rst;
                if (out_ready) begin
                    state_n = in_valid ? CONV : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                bin   <= in_data;
                bcd   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (state == CONV) begin
                bin   <= bin << 1;
                bcd   <= bcd_sh;
                count <= count + CW'(1);
                ovf   <= ovf | carry;
            end
        end
    end

    assign bcd_out  = bcd;
    assign overflow = ovf;

endmodule
